// File: rtl/vcpu_pkg.sv
// Shared types and constants for the vcpu bus arbiter.
package vcpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } state_t;

    typedef logic [31:0] word_t;

    localparam logic [1:0] REQ_DATA  = 2'd0;
    localparam logic [1:0] REQ_STACK = 2'd1;
    localparam logic [1:0] REQ_FETCH = 2'd2;

    function automatic word_t pick_word(
        input logic [95:0] v,
        input logic [1:0]  i
    );
        case (i)
            REQ_STACK: return v[63:32];
            REQ_FETCH: return v[95:64];
            default:   return v[31:0];
        endcase
    endfunction

endpackage

// File: rtl/vcpu_arb_prio.sv
// Fixed-priority pick (stack > data > fetch) with a starve override for fetch.
module vcpu_arb_prio
    import vcpu_pkg::*;
(
    input  logic [2:0] req,
    input  logic       starve,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        if (starve && req[REQ_FETCH]) begin
            grant[REQ_FETCH] = 1'b1;
        end else if (req[REQ_STACK]) begin
            grant[REQ_STACK] = 1'b1;
        end else if (req[REQ_DATA]) begin
            grant[REQ_DATA] = 1'b1;
        end else if (req[REQ_FETCH]) begin
            grant[REQ_FETCH] = 1'b1;
        end
    end

endmodule

// File: rtl/vcpu_bus_arbiter.sv
// Three-requester memory bus arbiter with lock, starve and timeout handling.
module vcpu_bus_arbiter
    import vcpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        in_CLK,
    input  logic        in_RESET,
    input  logic [2:0]  in_REQ,
    input  logic [95:0] in_ADDR,
    input  logic [2:0]  in_WE,
    input  logic [95:0] in_WDATA,
    input  logic [2:0]  in_LOCK,
    output logic [2:0]  out_ACK,
    output logic        out_ERR,
    output word_t       out_RDATA,
    output logic        out_MEM_VALID,
    output word_t       out_MEM_ADDR,
    output logic        out_MEM_WE,
    output word_t       out_MEM_WDATA,
    input  logic        in_MEM_READY,
    input  word_t       in_MEM_RDATA,
    output logic        out_BUSY
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] S_MAX  = SW'(STARVE_LIMIT);

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] scnt;
    logic          lock_q;
    logic [1:0]    cur;

    logic [2:0] grant;
    logic [1:0] win;
    logic [1:0] nidx;
    logic       starve;
    logic       arb;
    logic       lock_cont;
    logic       take;

    assign starve = (scnt == S_MAX);

    vcpu_arb_prio u_prio (
        .req    (in_REQ),
        .starve (starve),
        .grant  (grant)
    );

    always_comb begin
        win = REQ_DATA;
        unique case (1'b1)
            grant[REQ_STACK]: win = REQ_STACK;
            grant[REQ_FETCH]: win = REQ_FETCH;
            default:          win = REQ_DATA;
        endcase
    end

    // A locked requester that is still asking in DONE keeps the bus outright.
    assign arb       = (state == ST_IDLE) || (state == ST_DONE);
    assign lock_cont = (state == ST_DONE) && lock_q
                     && in_LOCK[cur] && in_REQ[cur];
    assign take      = lock_cont || (|in_REQ);
    assign nidx      = lock_cont ? cur : win;

    always_ff @(posedge in_CLK) begin
        if (in_RESET) begin
            state         <= ST_IDLE;
            tcnt          <= '0;
            scnt          <= '0;
            lock_q        <= 1'b0;
            cur           <= REQ_DATA;
            out_ACK       <= '0;
            out_ERR       <= 1'b0;
            out_RDATA     <= '0;
            out_MEM_VALID <= 1'b0;
            out_MEM_ADDR  <= '0;
            out_MEM_WE    <= 1'b0;
            out_MEM_WDATA <= '0;
            out_BUSY      <= 1'b0;
        end else begin
            out_ACK <= '0;
            out_ERR <= 1'b0;

            if (!lock_cont) begin
                if (!in_REQ[REQ_FETCH] || (arb && nidx == REQ_FETCH)) begin
                    scnt <= '0;
                end else if (arb && scnt != S_MAX) begin
                    scnt <= scnt + 1'b1;
                end
            end

            unique case (state)
                ST_BUS: begin
                    if (in_MEM_READY || tcnt == T_LAST) begin
                        state         <= ST_DONE;
                        out_MEM_VALID <= 1'b0;
                        out_ACK       <= 3'b001 << cur;
                        out_ERR       <= !in_MEM_READY;
                        if (!in_MEM_READY) begin
                            out_RDATA <= '0;
                            lock_q    <= 1'b0;
                        end else if (!out_MEM_WE) begin
                            out_RDATA <= in_MEM_RDATA;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    if (take) begin
                        state         <= ST_BUS;
                        out_BUSY      <= 1'b1;
                        out_MEM_VALID <= 1'b1;
                        cur           <= nidx;
                        out_MEM_ADDR  <= pick_word(in_ADDR, nidx);
                        out_MEM_WE    <= in_WE[nidx];
                        out_MEM_WDATA <= pick_word(in_WDATA, nidx);
                        lock_q        <= in_LOCK[nidx];
                        tcnt          <= '0;
                    end else begin
                        state    <= ST_IDLE;
                        out_BUSY <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vcpu_bus_arbiter.sv
// Bench for vcpu_bus_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of arbitration and memory.
module tb_vcpu_bus_arbiter;
    import vcpu_pkg::*;

    localparam int T     = 8;
    localparam int S     = 4;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, we, lock;
    logic [95:0] addr, wdata;
    logic [2:0]  ack;
    logic        err, mvalid, mwe, mready, busy;
    word_t       rdata, maddr, mwdata, mrdata;

    vcpu_bus_arbiter #(.TIMEOUT_CYCLES(T), .STARVE_LIMIT(S)) dut (
        .in_CLK        (clk),
        .in_RESET      (rst),
        .in_REQ        (req),
        .in_ADDR       (addr),
        .in_WE         (we),
        .in_WDATA      (wdata),
        .in_LOCK       (lock),
        .out_ACK       (ack),
        .out_ERR       (err),
        .out_RDATA     (rdata),
        .out_MEM_VALID (mvalid),
        .out_MEM_ADDR  (maddr),
        .out_MEM_WE    (mwe),
        .out_MEM_WDATA (mwdata),
        .in_MEM_READY  (mready),
        .in_MEM_RDATA  (mrdata),
        .out_BUSY      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    idx;
        word_t a;
        logic  w;
        word_t d;
        logic  l;
        int    g;
        int    lat;
    } txn_t;

    txn_t       cur;
    bit         outst, just_done, last_lock, rand_mode, busy_low;
    int         last_idx, scnt, edge_no, lat_next, checks, errors;
    logic [2:0] drop_mask, last_ack;
    word_t      rdata_exp;
    word_t      mem [word_t];
    logic [2:0] log_q [$];

    function automatic word_t memread(input word_t a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_1234);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int w;
        int ae;
        bit cont;
        bit grant;
        bit ev;
        logic [2:0] ea;
        w = 0;
        cont = 0;
        grant = 0;
        if (rst) begin
            outst = 0;
            just_done = 0;
            last_lock = 0;
            scnt = 0;
            rdata_exp = '0;
        end else begin
            if (!outst) begin
                cont = just_done && last_lock
                     && req[last_idx] && lock[last_idx];
                if (cont) w = last_idx;
                else if (scnt == S && req[2]) w = 2;
                else if (req[1]) w = 1;
                else if (req[0]) w = 0;
                else w = 2;
                grant = cont || (req != 0);
                if (grant) begin
                    cur.idx = w;
                    cur.a   = addr[32*w +: 32];
                    cur.w   = we[w];
                    cur.d   = wdata[32*w +: 32];
                    cur.l   = lock[w];
                    cur.g   = edge_no + 1;
                    if (rand_mode)
                        cur.lat = ($urandom_range(0, 15) == 0)
                                ? NEVER : int'($urandom_range(0, 3));
                    else
                        cur.lat = lat_next;
                    outst = 1;
                end
            end
            if (!cont) begin
                if (!req[2] || (grant && w == 2)) scnt = 0;
                else if (grant && scnt < S) scnt++;
            end
            just_done = 0;
        end

        @(posedge clk);
        #1;
        edge_no++;

        ae = cur.g + 1 + ((cur.lat < T) ? cur.lat : T - 1);
        ea = (outst && edge_no == ae) ? 3'(1 << cur.idx) : 3'b000;
        ev = outst && edge_no >= cur.g && edge_no < ae;
        check("ack", 32'(ack), 32'(ea));
        check("mem_valid", 32'(mvalid), 32'(ev));
        check("busy", 32'(busy), 32'(outst));
        check("err", 32'(err), (ea != 0 && cur.lat >= T) ? 1 : 0);
        if (ea != 0) begin
            check("mem_addr", maddr, cur.a);
            check("mem_we", 32'(mwe), 32'(cur.w));
            if (cur.w) check("mem_wdata", mwdata, cur.d);
            if (cur.lat >= T) rdata_exp = '0;
            else if (cur.w) mem[cur.a] = cur.d;
            else rdata_exp = memread(cur.a);
            last_idx  = cur.idx;
            last_lock = cur.l && (cur.lat < T);
            just_done = 1;
            outst = 0;
        end
        check("rdata", rdata, rdata_exp);
        if (ack != 0) log_q.push_back(ack);
        if (!busy) busy_low = 1;
        last_ack = ea;
        for (int i = 0; i < 3; i++)
            if (ea[i] && drop_mask[i]) req[i] = 1'b0;

        mready = outst && (edge_no - cur.g == cur.lat);
        mrdata = mready ? memread(cur.a) : $urandom();

        if (rand_mode) begin
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && !(outst && cur.idx == i)
                    && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    we[i] = 1'($urandom_range(0, 1));
                    addr[32*i +: 32] = 32'h100 + 32'(4 * $urandom_range(0, 3));
                    wdata[32*i +: 32] = $urandom();
                end else if (req[i] && outst && cur.idx == i
                    && edge_no > cur.g && $urandom_range(0, 7) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int max);
        for (int n = 0; n < max; n++) begin
            step();
            if (!outst && req == 0) return;
        end
        checks++;
        errors++;
        $error("FAIL drain observed=busy expected=idle");
    endtask

    task automatic wait_ack(input int i, input int max);
        for (int n = 0; n < max; n++) begin
            step();
            if (last_ack[i]) return;
        end
        checks++;
        errors++;
        $error("FAIL wait_ack%0d observed=none expected=ack", i);
    endtask

    initial begin
        rst = 1'b1;
        req = '0; we = '0; lock = '0;
        addr = '0; wdata = '0;
        mready = 1'b0; mrdata = '0;
        drop_mask = 3'b111;
        lat_next = 0; rand_mode = 0; busy_low = 0;
        outst = 0; just_done = 0; last_lock = 0;
        last_idx = 0; scnt = 0; edge_no = 0;
        checks = 0; errors = 0;
        rdata_exp = '0; last_ack = '0;

        // reset state
        step();
        step();
        check("rst_addr", maddr, 32'h0);
        check("rst_we", 32'(mwe), 32'h0);
        check("rst_wdata", mwdata, 32'h0);
        rst = 1'b0;
        step();

        // all three at once: order 1,0,2
        log_q.delete();
        for (int i = 0; i < 3; i++) addr[32*i +: 32] = 32'h4000 + 32'(i * 16);
        req = 3'b111;
        drain(40);
        check("order_n", 32'(log_q.size()), 32'd3);
        check("order_0", 32'(log_q[0]), 32'b010);
        check("order_1", 32'(log_q[1]), 32'b001);
        check("order_2", 32'(log_q[2]), 32'b100);

        // read data held until the next read completes
        mem[32'h2000] = 32'hDEAD_BEEF;
        addr[31:0] = 32'h2000;
        req = 3'b001;
        drain(20);
        check("rd_beef", rdata, 32'hDEAD_BEEF);
        addr[63:32] = 32'h2004; we[1] = 1'b1;
        wdata[63:32] = 32'h1111_2222;
        req = 3'b010;
        drain(20);
        check("rd_hold_wr", rdata, 32'hDEAD_BEEF);
        repeat (3) step();
        check("rd_hold_idle", rdata, 32'hDEAD_BEEF);
        we = '0;
        addr[95:64] = 32'h2004;
        req = 3'b100;
        drain(20);
        check("rd_new", rdata, 32'h1111_2222);

        // prefetch starvation: four data grants then fetch
        log_q.delete();
        drop_mask = 3'b110;
        addr[31:0] = 32'h3000; addr[95:64] = 32'h3100;
        req = 3'b101;
        for (int n = 0; n < 60 && log_q.size() < 5; n++) step();
        req[0] = 1'b0;
        drop_mask = 3'b111;
        drain(40);
        for (int k = 0; k < 4; k++) check("starve_d", 32'(log_q[k]), 32'b001);
        check("starve_f", 32'(log_q[4]), 32'b100);

        // locked read-modify-write beats a waiting stack request
        log_q.delete();
        drop_mask = 3'b010;
        addr[31:0] = 32'h1000; we[0] = 1'b0; lock[0] = 1'b1;
        req = 3'b001; lat_next = 1;
        step();
        busy_low = 0;
        addr[63:32] = 32'h5000; we[1] = 1'b0; req[1] = 1'b1;
        wait_ack(0, 20);
        we[0] = 1'b1; wdata[31:0] = 32'h1234_5678;
        wait_ack(0, 20);
        req[0] = 1'b0; lock[0] = 1'b0;
        drain(20);
        check("lock_busy", 32'(busy_low), 32'd0);
        check("lock_0", 32'(log_q[0]), 32'b001);
        check("lock_1", 32'(log_q[1]), 32'b001);
        check("lock_2", 32'(log_q[2]), 32'b010);

        // timeout aborts and releases the lock
        log_q.delete();
        we = '0; lock[0] = 1'b1;
        req = 3'b001; lat_next = NEVER;
        step();
        lat_next = 0;
        addr[63:32] = 32'h5004; req[1] = 1'b1;
        wait_ack(0, 20);
        check("to_rdata", rdata, 32'h0);
        step();
        req[0] = 1'b0; lock[0] = 1'b0;
        drain(20);
        check("to_0", 32'(log_q[0]), 32'b001);
        check("to_1", 32'(log_q[1]), 32'b010);

        // reset in the middle of a bus cycle
        log_q.delete();
        drop_mask = 3'b111;
        addr[31:0] = 32'h6000;
        req = 3'b001; lat_next = NEVER;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0; req = '0; lat_next = 0;
        check("rst_bus_valid", 32'(mvalid), 32'h0);
        repeat (12) step();
        check("rst_bus_noack", 32'(log_q.size()), 32'd0);

        // random traffic
        rand_mode = 1;
        repeat (400) step();
        rand_mode = 0;
        req = '0;
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
